// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, 12-bit colour type and colour constants
// shared by the VGA driver and its counter sub-module.
package vga_pkg;

  localparam int VGA_640x480_H_ACTIVE = 640;
  localparam int VGA_640x480_H_FP     = 16;
  localparam int VGA_640x480_H_SYNC   = 96;
  localparam int VGA_640x480_H_BP     = 48;
  localparam int VGA_640x480_V_ACTIVE = 480;
  localparam int VGA_640x480_V_FP     = 10;
  localparam int VGA_640x480_V_SYNC   = 2;
  localparam int VGA_640x480_V_BP     = 33;

  typedef logic [11:0] rgb12_t;  // {R[3:0], G[3:0], B[3:0]}

  localparam rgb12_t VGA_FG_COLOR     = 12'hFFF;
  localparam rgb12_t VGA_BG_COLOR     = 12'h000;
  localparam rgb12_t VGA_BORDER_COLOR = 12'h00F;

endpackage

// File: rtl/vga_wrap_counter.sv
// Enabled up-counter 0..p_max; wrap pulses combinationally on the enabled cycle
// that returns the count to 0. Synchronous active-high reset clears the count.
module vga_wrap_counter #(
  parameter int p_max   = 799,
  parameter int p_width = $clog2(p_max + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [p_width-1:0] count,
  output logic               wrap
);

  localparam logic [p_width-1:0] COUNT_MAX = p_width'(p_max);

  assign wrap = en && (count == COUNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_driver.sv
// VGA timing + char-buffer addressing; counters -> pins is 2 cycles, free-running (no backpressure).
// Build option VGA_DRIVER_BORDER_EN: in-region out_of_bounds pixels show p_border_color instead of p_bg_color.
module vga_driver
  import vga_pkg::*;
#(
  parameter int     p_h_active = VGA_640x480_H_ACTIVE,
  parameter int     p_h_fp     = VGA_640x480_H_FP,
  parameter int     p_h_sync   = VGA_640x480_H_SYNC,
  parameter int     p_h_bp     = VGA_640x480_H_BP,
  parameter int     p_v_active = VGA_640x480_V_ACTIVE,
  parameter int     p_v_fp     = VGA_640x480_V_FP,
  parameter int     p_v_sync   = VGA_640x480_V_SYNC,
  parameter int     p_v_bp     = VGA_640x480_V_BP,
  parameter bit     p_sync_pol = 1'b0,
  parameter rgb12_t p_fg_color = VGA_FG_COLOR,
  parameter rgb12_t p_bg_color = VGA_BG_COLOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  read_hchar,
  output logic [4:0]  read_vchar,
  output logic [2:0]  read_hoffset,
  output logic [3:0]  read_voffset,
  input  logic        read_lit,
  input  logic        out_of_bounds,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output rgb12_t      vga_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = p_h_active + p_h_fp + p_h_sync + p_h_bp;
  localparam int V_TOTAL = p_v_active + p_v_fp + p_v_sync + p_v_bp;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT        = HW'(p_h_active);
  localparam logic [HW-1:0] H_SYNC_START = HW'(p_h_active + p_h_fp);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(p_h_active + p_h_fp + p_h_sync);
  localparam logic [VW-1:0] V_ACT        = VW'(p_v_active);
  localparam logic [VW-1:0] V_SYNC_START = VW'(p_v_active + p_v_fp);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(p_v_active + p_v_fp + p_v_sync);

`ifdef VGA_DRIVER_BORDER_EN
  localparam rgb12_t p_border_color = VGA_BORDER_COLOR;
  localparam rgb12_t OOB_COLOR      = p_border_color;
`else
  localparam rgb12_t OOB_COLOR      = p_bg_color;
`endif

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          h_wrap;
  logic          v_wrap_unused;

  vga_wrap_counter #(.p_max(H_TOTAL - 1)) u_hcount (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (hcount),
    .wrap  (h_wrap)
  );

  vga_wrap_counter #(.p_max(V_TOTAL - 1)) u_vcount (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (vcount),
    .wrap  (v_wrap_unused)
  );

  // Stage0: address slices assume a 10-bit hcount / 9-bit vcount view of the counters.
  logic       active;
  logic       hsync_on;
  logic       vsync_on;
  logic [9:0] h_addr;
  logic [8:0] v_addr;

  assign active   = (hcount < H_ACT) && (vcount < V_ACT);
  assign hsync_on = (hcount >= H_SYNC_START) && (hcount < H_SYNC_END);
  assign vsync_on = (vcount >= V_SYNC_START) && (vcount < V_SYNC_END);
  assign h_addr   = 10'(hcount);
  assign v_addr   = 9'(vcount);

  assign read_hchar   = active ? h_addr[9:3] : '0;
  assign read_hoffset = active ? h_addr[2:0] : '0;
  assign read_vchar   = active ? v_addr[8:4] : '0;
  assign read_voffset = active ? v_addr[3:0] : '0;

  // Stage1: timing flags held in "asserted" sense; pin polarity is applied at stage2.
  logic active_d;
  logic hsync_d;
  logic vsync_d;
  logic sof_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_d <= 1'b0;
      hsync_d  <= 1'b0;
      vsync_d  <= 1'b0;
      sof_d    <= 1'b0;
    end else begin
      active_d <= active;
      hsync_d  <= hsync_on;
      vsync_d  <= vsync_on;
      sof_d    <= (hcount == '0) && (vcount == '0);
    end
  end

  rgb12_t pixel_color;

  always_comb begin
    pixel_color = '0;
    if (active_d) begin
      if (out_of_bounds) begin
        pixel_color = OOB_COLOR;
      end else if (read_lit) begin
        pixel_color = p_fg_color;
      end else begin
        pixel_color = p_bg_color;
      end
    end
  end

  // Stage2: pin registers; read_lit/out_of_bounds arrive here aligned with stage1.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync   <= ~p_sync_pol;
      vga_vsync   <= ~p_sync_pol;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= hsync_d ? p_sync_pol : ~p_sync_pol;
      vga_vsync   <= vsync_d ? p_sync_pol : ~p_sync_pol;
      vga_rgb     <= pixel_color;
      frame_start <= sof_d;
    end
  end

endmodule
